// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, FSM states and the
// per-opcode rule for which flags an operation updates.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDZ = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_LHB  = 4'b1010;
  localparam logic [3:0] OP_LLB  = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FM_ALL    = 2'd0,
    FM_Z_ONLY = 2'd1,
    FM_NONE   = 2'd2
  } flag_mask_e;

  function automatic flag_mask_e flag_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDZ, OP_SUB, OP_MUL:         return FM_ALL;
      OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA:  return FM_Z_ONLY;
      default:                                 return FM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/result bundle between the register-read stage, the ALU and writeback.
// Handshake: an op transfers on a rising edge where in_valid && in_ready; out_valid is a one-cycle pulse with no backpressure.
`timescale 1ns/1ps
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic [WIDTH-1:0] dst;
  logic             wb_en;
  logic             ov;
  logic             zr;
  logic             neg;

  modport master (
    output in_valid, op, src0, src1, shamt,
    input  in_ready, out_valid, dst, wb_en, ov, zr, neg
  );

  modport slave (
    input  in_valid, op, src0, src1, shamt,
    output in_ready, out_valid, dst, wb_en, ov, zr, neg
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one partial product per cycle.
// done/product describe the step being completed on the current edge.
`timescale 1ns/1ps
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] step_acc;

  assign step_acc = acc + (mplier[0] ? mcand : '0);
  assign product  = step_acc;
  assign done     = busy && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with saturating add/sub/mul, persistent flags,
// conditional ADDZ and a sequential signed multiply.
`timescale 1ns/1ps
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_pipe_if.slave    bus,
  output state_e       dbg_state
);
  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state;
  logic               mul_sign;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_mag;
  logic [WIDTH-1:0]   abs0, abs1;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_res;

  logic [WIDTH-1:0]   sum, diff, sra_res;
  logic               add_ovf, sub_ovf;
  logic [WIDTH-1:0]   res;
  logic               res_ov, res_wb;
  flag_mask_e         res_mask;

  assign bus.in_ready = (state == ST_IDLE);
  assign dbg_state    = state;

  assign sum     = bus.src0 + bus.src1;
  assign diff    = bus.src0 - bus.src1;
  assign add_ovf = (bus.src0[WIDTH-1] == bus.src1[WIDTH-1]) && (sum[WIDTH-1]  != bus.src0[WIDTH-1]);
  assign sub_ovf = (bus.src0[WIDTH-1] != bus.src1[WIDTH-1]) && (diff[WIDTH-1] != bus.src0[WIDTH-1]);
  assign sra_res = $signed(bus.src0) >>> bus.shamt;

  always_comb begin
    res      = '0;
    res_ov   = 1'b0;
    res_wb   = 1'b1;
    res_mask = flag_mask(bus.op);
    case (bus.op)
      OP_ADD: begin
        res    = add_ovf ? (bus.src0[WIDTH-1] ? MAX_NEG : MAX_POS) : sum;
        res_ov = add_ovf;
      end
      OP_ADDZ: begin
        // Taken only when the previous op left zr set; otherwise a write-less pulse.
        if (bus.zr) begin
          res    = add_ovf ? (bus.src0[WIDTH-1] ? MAX_NEG : MAX_POS) : sum;
          res_ov = add_ovf;
        end else begin
          res_wb   = 1'b0;
          res_mask = FM_NONE;
        end
      end
      OP_SUB: begin
        res    = sub_ovf ? (bus.src0[WIDTH-1] ? MAX_NEG : MAX_POS) : diff;
        res_ov = sub_ovf;
      end
      OP_AND: res = bus.src0 & bus.src1;
      OP_NOR: res = ~(bus.src0 | bus.src1);
      OP_SLL: res = bus.src0 << bus.shamt;
      OP_SRL: res = bus.src0 >> bus.shamt;
      OP_SRA: res = sra_res;
      OP_LHB: res = {bus.src1[H-1:0], bus.src0[H-1:0]};
      OP_LLB: res = {{H{bus.src1[H-1]}}, bus.src1[H-1:0]};
      default: res_wb = 1'b0;
    endcase
  end

  assign mul_start = (state == ST_IDLE) && bus.in_valid && (bus.op == OP_MUL);
  assign abs0      = bus.src0[WIDTH-1] ? -bus.src0 : bus.src0;
  assign abs1      = bus.src1[WIDTH-1] ? -bus.src1 : bus.src1;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (abs0),
    .b       (abs1),
    .done    (mul_done),
    .product (mul_mag)
  );

  // A negative product may reach exactly 2^(WIDTH-1) in magnitude; a positive one may not.
  always_comb begin
    if (mul_sign)
      mul_ovf = (mul_mag[2*WIDTH-1:WIDTH] != '0) || (mul_mag[WIDTH-1] && (mul_mag[WIDTH-2:0] != '0));
    else
      mul_ovf = (mul_mag[2*WIDTH-1:WIDTH-1] != '0);
    if (mul_ovf)
      mul_res = mul_sign ? MAX_NEG : MAX_POS;
    else
      mul_res = mul_sign ? -mul_mag[WIDTH-1:0] : mul_mag[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mul_sign      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.dst       <= '0;
      bus.wb_en     <= 1'b0;
      bus.ov        <= 1'b0;
      bus.zr        <= 1'b0;
      bus.neg       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.wb_en     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_MUL) begin
              state    <= ST_MUL;
              mul_sign <= bus.src0[WIDTH-1] ^ bus.src1[WIDTH-1];
            end else begin
              bus.out_valid <= 1'b1;
              bus.dst       <= res;
              bus.wb_en     <= res_wb;
              case (res_mask)
                FM_ALL: begin
                  bus.ov  <= res_ov;
                  bus.zr  <= (res == '0);
                  bus.neg <= res[WIDTH-1];
                end
                FM_Z_ONLY: bus.zr <= (res == '0);
                default: ;
              endcase
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b1;
            bus.dst       <= mul_res;
            bus.wb_en     <= 1'b1;
            bus.ov        <= mul_ovf;
            bus.zr        <= (mul_res == '0);
            bus.neg       <= mul_res[WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
